// File: rtl/sap_control_sequencer.sv
// SAP-U control sequencer: five-step T-counter plus opcode decode
// into the bus, register, PC, memory and ALU control word.
module sap_control_sequencer #(
  parameter int STEPS = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] instr,
  input  logic [1:0] flags,
  output logic [2:0] step,
  output logic       hlt,
  output logic       mi,
  output logic       ri,
  output logic       ro,
  output logic       ii,
  output logic       io,
  output logic       ai,
  output logic       ao,
  output logic       bi,
  output logic       oi,
  output logic       ce,
  output logic       co,
  output logic       j,
  output logic       alu_enable,
  output logic       subtract,
  output logic       flag_fi,
  output logic       flag_clr
);

  localparam logic [2:0] LAST = 3'(STEPS - 1);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [3:0] op;
  logic [2:0] step_q, step_d;
  logic       halted_q, halted_d;
  logic       operand_unused;

  assign op             = instr[7:4];
  assign operand_unused = ^instr[3:0];
  assign step           = step_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Halting freezes the counter on the step after T2 (i.e. T3).
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      step_d   = (step_q == LAST) ? 3'd0 : step_q + 3'd1;
      halted_d = (step_q == 3'd2) && (op == OP_HLT);
    end
  end

  always_comb begin
    hlt        = 1'b0;
    mi         = 1'b0;
    ri         = 1'b0;
    ro         = 1'b0;
    ii         = 1'b0;
    io         = 1'b0;
    ai         = 1'b0;
    ao         = 1'b0;
    bi         = 1'b0;
    oi         = 1'b0;
    ce         = 1'b0;
    co         = 1'b0;
    j          = 1'b0;
    alu_enable = 1'b1;
    subtract   = 1'b0;
    flag_fi    = 1'b1;
    flag_clr   = clr;
    if (clr) begin
      hlt = 1'b0;
    end else if (halted_q) begin
      hlt = 1'b1;
    end else begin
      case (step_q)
        3'd0: begin
          co = 1'b1;
          mi = 1'b1;
        end
        3'd1: begin
          ro = 1'b1;
          ii = 1'b1;
          ce = 1'b1;
        end
        3'd2: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              io = 1'b1;
              mi = 1'b1;
            end
            OP_LDI: begin
              io = 1'b1;
              ai = 1'b1;
            end
            OP_JMP: begin
              io = 1'b1;
              j  = 1'b1;
            end
            OP_JC: begin
              io = 1'b1;
              j  = flags[0];
            end
            OP_JZ: begin
              io = 1'b1;
              j  = flags[1];
            end
            OP_OUT: begin
              ao = 1'b1;
              oi = 1'b1;
            end
            OP_HLT: hlt = 1'b1;
            default: hlt = 1'b0;
          endcase
        end
        3'd3: begin
          case (op)
            OP_LDA: begin
              ro = 1'b1;
              ai = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ro = 1'b1;
              bi = 1'b1;
            end
            OP_STA: begin
              ao = 1'b1;
              ri = 1'b1;
            end
            default: hlt = 1'b0;
          endcase
        end
        3'd4: begin
          if (op == OP_ADD || op == OP_SUB) begin
            alu_enable = 1'b0;
            ai         = 1'b1;
            flag_fi    = 1'b0;
            subtract   = (op == OP_SUB);
          end
        end
        default: hlt = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Random and directed bench for sap_control_sequencer against a
// cycle-level instruction model built from the microcode table.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] instr = 8'h00;
  logic [1:0] flags = 2'b00;
  logic [2:0] step;
  logic hlt, mi, ri, ro, ii, io, ai, ao, bi, oi, ce, co, j;
  logic alu_enable, subtract, flag_fi, flag_clr;

  int n_tests = 0;
  int n_fail  = 0;

  // control-word bit positions; ALU and FI bits are "asserted" meaning pin low
  localparam int B_HLT = 16, B_MI = 15, B_RI = 14, B_RO = 13, B_II = 12;
  localparam int B_IO = 11, B_AI = 10, B_AO = 9, B_BI = 8, B_OI = 7;
  localparam int B_CE = 6, B_CO = 5, B_J = 4, B_ALU = 3, B_SUB = 2;
  localparam int B_FI = 1, B_FCLR = 0;
  localparam logic [16:0] INV = (17'd1 << B_ALU) | (17'd1 << B_FI);

  int m_step   = 0;
  bit m_halted = 1'b0;
  int halt_len = 0;

  always #5 clk = ~clk;

  sap_control_sequencer #(.STEPS(5)) dut (
    .clk(clk), .clr(clr), .instr(instr), .flags(flags), .step(step),
    .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .ii(ii), .io(io), .ai(ai),
    .ao(ao), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j),
    .alu_enable(alu_enable), .subtract(subtract), .flag_fi(flag_fi),
    .flag_clr(flag_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] bitset(input int b);
    return 17'd1 << b;
  endfunction

  // Expected pin levels from the instruction table.
  function automatic logic [16:0] model_word(input int s, input bit h,
      input logic [7:0] ins, input logic [1:0] f, input bit c);
    logic [16:0] a;
    int o;
    a = '0;
    o = int'(ins[7:4]);
    if (c) a = bitset(B_FCLR);
    else if (h) a = bitset(B_HLT);
    else if (s == 0) a = bitset(B_CO) | bitset(B_MI);
    else if (s == 1) a = bitset(B_RO) | bitset(B_II) | bitset(B_CE);
    else if (s == 2) begin
      if (o >= 1 && o <= 4) a = bitset(B_IO) | bitset(B_MI);
      else if (o == 5) a = bitset(B_IO) | bitset(B_AI);
      else if (o == 6) a = bitset(B_IO) | bitset(B_J);
      else if (o == 7) a = bitset(B_IO) | (f[0] ? bitset(B_J) : 17'd0);
      else if (o == 8) a = bitset(B_IO) | (f[1] ? bitset(B_J) : 17'd0);
      else if (o == 14) a = bitset(B_AO) | bitset(B_OI);
      else if (o == 15) a = bitset(B_HLT);
    end else if (s == 3) begin
      if (o == 1) a = bitset(B_RO) | bitset(B_AI);
      else if (o == 2 || o == 3) a = bitset(B_RO) | bitset(B_BI);
      else if (o == 4) a = bitset(B_AO) | bitset(B_RI);
    end else if (s == 4) begin
      if (o == 2 || o == 3)
        a = bitset(B_ALU) | bitset(B_AI) | bitset(B_FI)
          | (o == 3 ? bitset(B_SUB) : 17'd0);
    end
    return a ^ INV;
  endfunction

  function automatic logic [16:0] dut_word();
    return {hlt, mi, ri, ro, ii, io, ai, ao, bi, oi, ce, co, j,
            alu_enable, subtract, flag_fi, flag_clr};
  endfunction

  task automatic compare(input string tag);
    chk({tag, "_step"}, 32'(step), 32'(m_step));
    chk({tag, "_word"}, 32'(dut_word()),
        32'(model_word(m_step, m_halted, instr, flags, clr)));
  endtask

  // One clock: inputs applied, outputs checked mid-cycle, model advances.
  task automatic run_cycle(input string tag, input logic [7:0] ins,
                           input logic [1:0] f);
    instr = ins;
    flags = f;
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    if (!clr) begin
      if (m_halted) halt_len++;
      else if (m_step == 2 && ins[7:4] == 4'hF) begin
        m_halted = 1'b1;
        m_step   = 3;
        halt_len = 0;
      end else m_step = (m_step + 1) % 5;
    end
    #1;
  endtask

  // Asynchronous clear asserted mid-cycle, held across one edge.
  task automatic pulse_clr(input string tag);
    #2;
    clr      = 1'b1;
    m_step   = 0;
    m_halted = 1'b0;
    #1;
    compare({tag, "_async"});
    @(posedge clk);
    #1;
    compare({tag, "_held"});
    clr = 1'b0;
  endtask

  task automatic run_instr(input string tag, input logic [7:0] ins,
                           input logic [1:0] f);
    for (int k = 0; k < 5; k++) run_cycle(tag, ins, f);
  endtask

  initial begin
    #1;
    compare("reset");
    @(posedge clk);
    #1;
    clr = 1'b0;

    run_instr("add", 8'h2E, 2'b00);
    run_instr("sub", 8'h3F, 2'b11);
    run_instr("jc1", 8'h74, 2'b01);
    run_instr("jc0", 8'h74, 2'b00);
    run_instr("jz1", 8'h85, 2'b10);
    run_instr("unused", 8'hA0, 2'b11);
    run_instr("lda", 8'h1C, 2'b00);
    run_instr("sta", 8'h4D, 2'b00);

    // clear in the middle of ADD T3
    for (int k = 0; k < 3; k++) run_cycle("add_mid", 8'h2E, 2'b00);
    pulse_clr("clr_t3");
    run_cycle("after_clr", 8'h2E, 2'b00);

    for (int k = 0; k < 4; k++) run_cycle("pre_hlt", 8'h00, 2'b00);
    for (int k = 0; k < 13; k++)
      run_cycle("hlt", 8'hF0, 2'($urandom));
    chk("hlt_frozen", {31'd0, m_halted}, 32'd1);
    pulse_clr("clr_hlt");

    for (int n = 0; n < 3000; n++) begin
      if ((m_halted && halt_len >= 10) || $urandom_range(0, 79) == 0)
        pulse_clr("rnd_clr");
      else
        run_cycle("rnd", 8'($urandom), 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
